// File: rtl/reg16_ce_clr.sv
// Clock-enabled data register with synchronous clear that takes priority over load.
// Define REG16_PARITY_EN to add a registered even-parity output bit alongside q.
module reg16_ce_clr #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clock,
    input  logic             clock_enable,
    input  logic             clear,
`ifdef REG16_PARITY_EN
    output logic [WIDTH-1:0] q,
    output logic             parity
`else
    output logic [WIDTH-1:0] q
`endif
);

    always_ff @(posedge clock) begin
        if (clear) begin
            q <= CLEAR_VALUE;
        end else if (clock_enable) begin
            q <= d;
        end
    end

`ifdef REG16_PARITY_EN
    // Parity is computed from the value being loaded, so it lands on the same edge as q.
    always_ff @(posedge clock) begin
        if (clear) begin
            parity <= ^CLEAR_VALUE;
        end else if (clock_enable) begin
            parity <= ^d;
        end
    end
`endif

endmodule

// File: tb/tb_reg16_ce_clr.sv
// Self-checking bench for reg16_ce_clr: directed test-plan steps followed by random traffic.
// The reference model tracks the register contents from the load/clear rules alone.
module tb_reg16_ce_clr;

    localparam int               WIDTH       = 16;
    localparam logic [WIDTH-1:0] CLEAR_VALUE = '0;

    logic             clock        = 1'b0;
    logic             clear        = 1'b0;
    logic             clock_enable = 1'b0;
    logic [WIDTH-1:0] d            = '0;
    logic [WIDTH-1:0] q;
`ifdef REG16_PARITY_EN
    logic             parity;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    logic [WIDTH-1:0] exp_q     = '0;
    bit               exp_known = 1'b0;

    reg16_ce_clr #(
        .WIDTH       (WIDTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) dut (
        .d            (d),
        .clock        (clock),
        .clock_enable (clock_enable),
        .clear        (clear),
`ifdef REG16_PARITY_EN
        .q            (q),
        .parity       (parity)
`else
        .q            (q)
`endif
    );

    always #5 clock = ~clock;

    // Until the first clear or load the register content is unspecified, so nothing is compared.
    task automatic checkOutput(input string tag);
        if (exp_known) begin
            assert_count++;
            assert (q === exp_q) else begin
                fail_count++;
                $error("[TB] FAIL %s: q observed %h expected %h", tag, q, exp_q);
            end
`ifdef REG16_PARITY_EN
            assert_count++;
            assert (parity === 1'($countones(exp_q) % 2)) else begin
                fail_count++;
                $error("[TB] FAIL %s_parity: parity observed %b expected %b",
                       tag, parity, 1'($countones(exp_q) % 2));
            end
`endif
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic ce,
                                 input logic [WIDTH-1:0] dv, input string tag);
        @(negedge clock);
        clear        = clr;
        clock_enable = ce;
        d            = dv;
        @(posedge clock);
        #1;
        if (clr) begin
            exp_q     = CLEAR_VALUE;
            exp_known = 1'b1;
        end else if (ce) begin
            exp_q     = dv;
            exp_known = 1'b1;
        end
        checkOutput(tag);
    endtask

    initial begin
        $display("[TB] starting reg16_ce_clr test");

        applyStimulus(1'b0, 1'b0, 16'h00FF, "powerup_hold0");
        applyStimulus(1'b0, 1'b0, 16'h00FF, "powerup_hold1");

        applyStimulus(1'b0, 1'b1, 16'h00FF, "load_00ff");
        applyStimulus(1'b0, 1'b1, 16'hAAAA, "reload_aaaa");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h1234, "hold_aaaa");
        end

        applyStimulus(1'b1, 1'b1, 16'h5555, "clear_beats_load");
        applyStimulus(1'b0, 1'b1, 16'hAAAA, "reload_aaaa2");
        applyStimulus(1'b1, 1'b0, 16'h1111, "clear_no_enable");
        applyStimulus(1'b0, 1'b1, 16'hFFFF, "load_ffff");

        // A clear pulse that starts and ends between edges must never reach q.
        @(negedge clock);
        clock_enable = 1'b0;
        clear        = 1'b1;
        #2;
        clear = 1'b0;
        checkOutput("clear_pulse_now");
        @(posedge clock);
        #1;
        checkOutput("clear_pulse_edge");

        applyStimulus(1'b0, 1'b1, 16'h0001, "load_0001");
        applyStimulus(1'b0, 1'b1, 16'h0003, "load_0003");

        // Random traffic, with d and enable disturbed mid-cycle to catch any combinational path.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          WIDTH'($urandom), "random");
            #2;
            d            = WIDTH'($urandom);
            clock_enable = 1'($urandom_range(0, 1));
            checkOutput("midcycle_stable");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
